// File: rtl/dm_sba_pkg.sv
// rtl/dm_sba_pkg.sv - shared types and constants for the system bus access block
package dm_sba_pkg;

   localparam logic [6:0] ADDR_SBCS       = 7'h38;
   localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
   localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;

   typedef enum logic [2:0] {
      SBERR_NONE    = 3'd0,
      SBERR_TIMEOUT = 3'd1,
      SBERR_BADADDR = 3'd2,
      SBERR_ALIGN   = 3'd3,
      SBERR_SIZE    = 3'd4
   } sberror_e;

   typedef struct packed {
      logic [2:0] sbversion;
      logic [5:0] rsvd;
      logic       sbbusyerror;
      logic       sbbusy;
      logic       sbreadonaddr;
      logic [2:0] sbaccess;
      logic       sbautoincrement;
      logic       sbreadondata;
      logic [2:0] sberror;
      logic [6:0] sbasize;
      logic       sbaccess128;
      logic       sbaccess64;
      logic       sbaccess32;
      logic       sbaccess16;
      logic       sbaccess8;
   } sbcs_t;

endpackage

// File: rtl/dm_sba.sv
// rtl/dm_sba.sv - debug module system bus access: sbcs/sbaddress0/sbdata0 and a
// single outstanding 32-bit bus access with error and timeout reporting
module dm_sba
   import dm_sba_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmactive,
   input  logic        dmi_req,
   input  logic        dmi_we,
   input  logic [6:0]  dmi_addr,
   input  logic [31:0] dmi_wdata,
   output logic [31:0] dmi_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t      state;
   logic [31:0] sbaddress0;
   logic [31:0] sbdata0;
   logic        sbbusyerror;
   logic        sbreadonaddr;
   logic        sbautoincrement;
   logic        sbreadondata;
   logic [2:0]  sbaccess;
   logic [2:0]  sberror;
   logic [7:0]  tmo_cnt;
   logic        bus_ok;

   sbcs_t       wr_sbcs;
   sbcs_t       rd_sbcs;
   logic        sel_sbcs, sel_addr, sel_data;
   logic        busy, busy_hit, trig, trig_we, timed_out;
   logic [31:0] trig_addr;
   logic        sbcs_unused;

   assign wr_sbcs  = sbcs_t'(dmi_wdata);
   assign sel_sbcs = dmi_req && (dmi_addr == ADDR_SBCS);
   assign sel_addr = dmi_req && (dmi_addr == ADDR_SBADDRESS0);
   assign sel_data = dmi_req && (dmi_addr == ADDR_SBDATA0);
   assign busy     = (state != IDLE);

   // Any data-path touch while an access is in flight is a busy error.
   assign busy_hit  = busy && ((sel_addr && dmi_we) || sel_data);
   assign trig      = !busy && ((sel_addr && dmi_we && sbreadonaddr) ||
                                (sel_data && dmi_we) ||
                                (sel_data && !dmi_we && sbreadondata));
   assign trig_we   = sel_data && dmi_we;
   assign trig_addr = (sel_addr && dmi_we) ? dmi_wdata : sbaddress0;
   assign timed_out = ({1'b0, tmo_cnt} + 9'd1) >= 9'(TIMEOUT);

   assign sbcs_unused = &{1'b0, wr_sbcs.sbversion, wr_sbcs.rsvd, wr_sbcs.sbbusy,
                          wr_sbcs.sbasize, wr_sbcs.sbaccess128, wr_sbcs.sbaccess64,
                          wr_sbcs.sbaccess32, wr_sbcs.sbaccess16, wr_sbcs.sbaccess8};

   always_comb begin
      rd_sbcs                 = '0;
      rd_sbcs.sbversion       = 3'd1;
      rd_sbcs.sbbusyerror     = sbbusyerror;
      rd_sbcs.sbbusy          = busy;
      rd_sbcs.sbreadonaddr    = sbreadonaddr;
      rd_sbcs.sbaccess        = sbaccess;
      rd_sbcs.sbautoincrement = sbautoincrement;
      rd_sbcs.sbreadondata    = sbreadondata;
      rd_sbcs.sberror         = sberror;
      rd_sbcs.sbasize         = 7'd32;
      rd_sbcs.sbaccess32      = 1'b1;
      case (dmi_addr)
         ADDR_SBCS:       dmi_rdata = rd_sbcs;
         ADDR_SBADDRESS0: dmi_rdata = sbaddress0;
         ADDR_SBDATA0:    dmi_rdata = sbdata0;
         default:         dmi_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         sbaddress0      <= '0;
         sbdata0         <= '0;
         sbbusyerror     <= 1'b0;
         sbreadonaddr    <= 1'b0;
         sbautoincrement <= 1'b0;
         sbreadondata    <= 1'b0;
         sbaccess        <= 3'd2;
         sberror         <= SBERR_NONE;
         tmo_cnt         <= '0;
         bus_ok          <= 1'b0;
         bus_req         <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= '0;
         bus_wdata       <= '0;
      end else if (!dmactive) begin
         state           <= IDLE;
         sbaddress0      <= '0;
         sbdata0         <= '0;
         sbbusyerror     <= 1'b0;
         sbreadonaddr    <= 1'b0;
         sbautoincrement <= 1'b0;
         sbreadondata    <= 1'b0;
         sbaccess        <= 3'd2;
         sberror         <= SBERR_NONE;
         tmo_cnt         <= '0;
         bus_ok          <= 1'b0;
         bus_req         <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= '0;
         bus_wdata       <= '0;
      end else begin
         if (sel_sbcs && dmi_we) begin
            sbreadonaddr    <= wr_sbcs.sbreadonaddr;
            sbaccess        <= wr_sbcs.sbaccess;
            sbautoincrement <= wr_sbcs.sbautoincrement;
            sbreadondata    <= wr_sbcs.sbreadondata;
            sberror         <= sberror & ~wr_sbcs.sberror;
            if (wr_sbcs.sbbusyerror) sbbusyerror <= 1'b0;
         end

         if (busy_hit) begin
            sbbusyerror <= 1'b1;
         end else if (!busy) begin
            if (sel_addr && dmi_we) sbaddress0 <= dmi_wdata;
            if (sel_data && dmi_we) sbdata0    <= dmi_wdata;
         end

         case (state)
            IDLE: begin
               if (trig && (sberror == SBERR_NONE) && !sbbusyerror) begin
                  if (sbaccess != 3'd2) begin
                     sberror <= SBERR_SIZE;
                  end else if (trig_addr[1:0] != 2'b00) begin
                     sberror <= SBERR_ALIGN;
                  end else begin
                     state     <= BUS;
                     bus_req   <= 1'b1;
                     bus_we    <= trig_we;
                     bus_addr  <= trig_addr;
                     bus_wdata <= trig_we ? dmi_wdata : sbdata0;
                     tmo_cnt   <= '0;
                     bus_ok    <= 1'b0;
                  end
               end
            end
            BUS: begin
               if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
               // ack outranks err when both arrive together
               if (bus_ack) begin
                  if (!bus_we) sbdata0 <= bus_rdata;
                  bus_ok <= 1'b1;
               end else if (bus_err) begin
                  sberror <= SBERR_BADADDR;
               end else if (timed_out) begin
                  sberror <= SBERR_TIMEOUT;
               end
               if (bus_ack || bus_err || timed_out) begin
                  bus_req <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (sbautoincrement && bus_ok) sbaddress0 <= sbaddress0 + 32'd4;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_sba.sv
// tb/tb_dm_sba.sv - scoreboard bench for dm_sba: transaction-level model predicts
// DMI read data and bus transactions, monitors compare what the DUT presents
module tb_dm_sba;
   import dm_sba_pkg::*;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_n, dmactive, dmi_req, dmi_we;
   logic [6:0]  dmi_addr;
   logic [31:0] dmi_wdata, dmi_rdata;
   logic        bus_req, bus_we, bus_ack, bus_err;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   dm_sba #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .dmactive(dmactive),
      .dmi_req(dmi_req), .dmi_we(dmi_we), .dmi_addr(dmi_addr),
      .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .bus_err(bus_err)
   );

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] rd_q[$];

   // reference model of the architectural state
   logic [31:0] m_addr, m_data;
   logic        m_busyerr, m_roa, m_autoinc, m_rod, m_busy, m_started, p_we;
   logic [2:0]  m_access, m_err;
   logic        abort_next;

   // bus responder configuration: kind 0=ack 1=err 2=silent 3=ack+err
   int          resp_lat, resp_kind;
   logic [31:0] resp_rdata;
   int          wcnt;

   assign bus_rdata = resp_rdata;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = '0; m_data = '0; m_busyerr = 0; m_roa = 0; m_autoinc = 0; m_rod = 0;
      m_access = 3'd2; m_err = 3'd0; m_busy = 0; m_started = 0; p_we = 0; abort_next = 0;
   endtask

   function automatic logic [31:0] sbcs_exp();
      return {3'd1, 6'd0, m_busyerr, m_busy, m_roa, m_access, m_autoinc, m_rod,
              m_err, 7'd32, 5'b00100};
   endfunction

   task automatic try_start(logic we);
      int h;
      if (m_err != 3'd0 || m_busyerr) return;
      if (m_access != 3'd2) m_err = 3'd4;
      else if (m_addr[1:0] != 2'b00) m_err = 3'd3;
      else begin
         h = abort_next ? -1 : (resp_kind == 2 ? TMO : resp_lat + 1);
         bus_q.push_back('{we, m_addr, m_data, h});
         m_busy = 1; m_started = 1; p_we = we; abort_next = 0;
      end
   endtask

   task automatic finish_model();
      if (!m_busy) return;
      case (resp_kind)
         1:       m_err = 3'd2;
         2:       m_err = 3'd1;
         default: begin
            if (!p_we) m_data = resp_rdata;
            if (m_autoinc) m_addr = m_addr + 32'd4;
         end
      endcase
      m_busy = 0;
   endtask

   task automatic drive(logic w, logic [6:0] a, logic [31:0] d);
      dmi_req = 1'b1; dmi_we = w; dmi_addr = a; dmi_wdata = d;
      @(posedge clk); #1;
      dmi_req = 1'b0; dmi_we = 1'b0;
   endtask

   task automatic dmi_write(logic [6:0] a, logic [31:0] d);
      m_started = 0;
      case (a)
         ADDR_SBCS: begin
            m_roa = d[20]; m_access = d[19:17]; m_autoinc = d[16]; m_rod = d[15];
            if (d[22]) m_busyerr = 0;
            m_err = m_err & ~d[14:12];
         end
         ADDR_SBADDRESS0: begin
            if (m_busy) m_busyerr = 1;
            else begin m_addr = d; if (m_roa) try_start(1'b0); end
         end
         ADDR_SBDATA0: begin
            if (m_busy) m_busyerr = 1;
            else begin m_data = d; try_start(1'b1); end
         end
         default: ;
      endcase
      drive(1'b1, a, d);
      if (m_started) check("bus_req_rise", {31'd0, bus_req}, 32'd1);
   endtask

   task automatic dmi_read(logic [6:0] a);
      m_started = 0;
      case (a)
         ADDR_SBCS:       rd_q.push_back(sbcs_exp());
         ADDR_SBADDRESS0: rd_q.push_back(m_addr);
         ADDR_SBDATA0: begin
            rd_q.push_back(m_data);
            if (m_busy) m_busyerr = 1;
            else if (m_rod) try_start(1'b0);
         end
         default:         rd_q.push_back(32'd0);
      endcase
      drive(1'b0, a, 32'd0);
      if (m_started) check("bus_req_rise", {31'd0, bus_req}, 32'd1);
   endtask

   task automatic read_const(logic [6:0] a, logic [31:0] exp);
      rd_q.push_back(exp);
      drive(1'b0, a, 32'd0);
   endtask

   task automatic cycles(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus_req && n < 600) begin @(posedge clk); #1; n++; end
      if (bus_req) begin
         vectors++; miscompares++;
         $display("FAIL wait_idle: bus_req still 1 after %0d cycles, want 0", n);
      end
      cycles(2);
      finish_model();
   endtask

   // bus responder
   initial begin
      bus_ack = 1'b0; bus_err = 1'b0; wcnt = 0;
      forever begin
         @(negedge clk);
         if (bus_req) begin
            bus_ack = (wcnt == resp_lat) && (resp_kind == 0 || resp_kind == 3);
            bus_err = (wcnt == resp_lat) && (resp_kind == 1 || resp_kind == 3);
            wcnt++;
         end else begin
            wcnt = 0; bus_ack = 1'b0; bus_err = 1'b0;
         end
      end
   end

   // DMI read monitor
   initial begin
      forever begin
         @(negedge clk);
         if (dmi_req && !dmi_we) begin
            if (rd_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL dmi_read: read of 0x%02h with no expectation queued", dmi_addr);
            end else begin
               check("dmi_rdata", dmi_rdata, rd_q.pop_front());
            end
         end
      end
   end

   // bus transaction monitor
   logic        mon_prev = 1'b0, mon_have = 1'b0, mon_stable = 1'b1;
   int          mon_hold = 0;
   bus_exp_t    mon_cur;
   logic [64:0] mon_cap;

   initial begin
      forever begin
         @(negedge clk);
         if (bus_req && !mon_prev) begin
            mon_hold = 1; mon_stable = 1'b1; mon_cap = {bus_we, bus_addr, bus_wdata};
            if (bus_q.size() == 0) begin
               vectors++; miscompares++; mon_have = 1'b0;
               $display("FAIL bus_unexpected: bus_req rose at addr 0x%08h, want no access", bus_addr);
            end else begin
               mon_cur = bus_q.pop_front(); mon_have = 1'b1;
               check("bus_we", {31'd0, bus_we}, {31'd0, mon_cur.we});
               check("bus_addr", bus_addr, mon_cur.addr);
               if (mon_cur.we) check("bus_wdata", bus_wdata, mon_cur.wdata);
            end
         end else if (bus_req) begin
            mon_hold++;
            if ({bus_we, bus_addr, bus_wdata} !== mon_cap) mon_stable = 1'b0;
         end else if (mon_prev && mon_have) begin
            if (mon_cur.hold >= 0) check("bus_hold_cycles", mon_hold, mon_cur.hold);
            check("bus_stable", {31'd0, mon_stable}, 32'd1);
            mon_have = 1'b0;
         end
         mon_prev = bus_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] r_val;
   logic [6:0]  r_a;
   int          r_op, r_k;

   initial begin
      rst_n = 1'b0; dmactive = 1'b1; dmi_req = 1'b0; dmi_we = 1'b0;
      dmi_addr = '0; dmi_wdata = '0;
      resp_lat = 0; resp_kind = 0; resp_rdata = '0;
      model_reset();
      cycles(3);
      rst_n = 1'b1;
      cycles(1);

      // reset state
      read_const(ADDR_SBCS, 32'h20040404);
      dmi_read(ADDR_SBADDRESS0);
      dmi_read(ADDR_SBDATA0);
      dmi_read(7'h10);

      // plain bus write, ack after 3 cycles
      resp_lat = 3; resp_kind = 0;
      dmi_write(ADDR_SBCS, 32'h00040000);
      dmi_write(ADDR_SBADDRESS0, 32'h00001000);
      dmi_write(ADDR_SBDATA0, 32'hDEADBEEF);
      dmi_read(ADDR_SBCS);
      wait_idle();
      dmi_read(ADDR_SBCS);

      // read-on-address with autoincrement
      resp_lat = 1; resp_rdata = 32'h12345678;
      dmi_write(ADDR_SBCS, 32'h00150000);
      dmi_write(ADDR_SBADDRESS0, 32'h00002000);
      wait_idle();
      dmi_read(ADDR_SBDATA0);
      dmi_read(ADDR_SBADDRESS0);

      // busy error while stalled, then blocked until cleared
      resp_lat = 20;
      dmi_write(ADDR_SBCS, 32'h00040000);
      dmi_write(ADDR_SBDATA0, 32'hA5A5A5A5);
      dmi_write(ADDR_SBDATA0, 32'h5A5A5A5A);
      wait_idle();
      dmi_read(ADDR_SBCS);
      dmi_write(ADDR_SBDATA0, 32'h11111111);
      wait_idle();
      dmi_read(ADDR_SBDATA0);
      dmi_write(ADDR_SBCS, 32'h00440000);
      dmi_write(ADDR_SBDATA0, 32'h22222222);
      wait_idle();
      dmi_read(ADDR_SBCS);

      // misaligned address, then W1C of sberror
      resp_lat = 0;
      dmi_write(ADDR_SBCS, 32'h00140000);
      dmi_write(ADDR_SBADDRESS0, 32'h00001002);
      wait_idle();
      dmi_read(ADDR_SBCS);
      dmi_write(ADDR_SBCS, 32'h00147000);
      dmi_read(ADDR_SBCS);

      // unsupported size
      dmi_write(ADDR_SBCS, 32'h00000000);
      dmi_write(ADDR_SBDATA0, 32'h33333333);
      wait_idle();
      dmi_read(ADDR_SBCS);
      dmi_write(ADDR_SBCS, 32'h00047000);

      // silent bus -> timeout
      resp_kind = 2;
      dmi_write(ADDR_SBADDRESS0, 32'h00005000);
      dmi_write(ADDR_SBDATA0, 32'hCAFEF00D);
      wait_idle();
      dmi_read(ADDR_SBCS);
      dmi_write(ADDR_SBCS, 32'h00047000);

      // ack and err together count as success
      resp_kind = 3; resp_lat = 2;
      dmi_write(ADDR_SBDATA0, 32'h0BADCAFE);
      wait_idle();
      dmi_read(ADDR_SBCS);

      // bus error
      resp_kind = 1; resp_lat = 0;
      dmi_write(ADDR_SBDATA0, 32'h44444444);
      wait_idle();
      dmi_read(ADDR_SBCS);
      dmi_write(ADDR_SBCS, 32'h00047000);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         resp_lat   = $urandom_range(0, 4);
         r_k        = $urandom_range(0, 19);
         resp_kind  = (r_k == 0) ? 2 : (r_k < 4) ? 1 : (r_k < 6) ? 3 : 0;
         resp_rdata = $urandom;
         r_op       = $urandom_range(0, 8);
         case (r_op)
            0, 1: begin
               r_val = $urandom;
               r_val[19:17] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
               dmi_write(ADDR_SBCS, r_val);
            end
            2, 3: begin
               r_val = $urandom;
               if ($urandom_range(0, 5) != 0) r_val[1:0] = 2'b00;
               dmi_write(ADDR_SBADDRESS0, r_val);
            end
            4:       dmi_write(ADDR_SBDATA0, $urandom);
            5:       dmi_read(ADDR_SBDATA0);
            6:       dmi_read(ADDR_SBCS);
            7:       dmi_read(ADDR_SBADDRESS0);
            default: begin
               r_a = 7'($urandom_range(0, 127));
               if ($urandom_range(0, 1) == 0) dmi_read(r_a);
               else dmi_write(r_a, $urandom);
            end
         endcase
         if (m_busy && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0:       dmi_read(ADDR_SBCS);
               1:       dmi_write(ADDR_SBDATA0, $urandom);
               default: dmi_read(ADDR_SBDATA0);
            endcase
         end
         wait_idle();
      end

      // dmactive=0 during a stalled access
      resp_kind = 2;
      dmi_write(ADDR_SBCS, 32'h00447000);
      dmi_write(ADDR_SBADDRESS0, 32'h00003000);
      abort_next = 1;
      dmi_write(ADDR_SBDATA0, 32'h55555555);
      cycles(5);
      dmactive = 1'b0;
      cycles(1);
      check("dmactive_bus_req", {31'd0, bus_req}, 32'd0);
      dmactive = 1'b1;
      model_reset();
      read_const(ADDR_SBCS, 32'h20040404);
      dmi_read(ADDR_SBADDRESS0);

      // asynchronous reset during a stalled access
      dmi_write(ADDR_SBADDRESS0, 32'h00004000);
      abort_next = 1;
      dmi_write(ADDR_SBDATA0, 32'h66666666);
      cycles(3);
      check("pre_reset_bus_req", {31'd0, bus_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_bus_req", {31'd0, bus_req}, 32'd0);
      check("reset_bus_we", {31'd0, bus_we}, 32'd0);
      check("reset_bus_addr", bus_addr, 32'd0);
      check("reset_bus_wdata", bus_wdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      cycles(1);
      read_const(ADDR_SBCS, 32'h20040404);
      dmi_read(ADDR_SBADDRESS0);
      dmi_read(ADDR_SBDATA0);

      cycles(3);
      check("bus_q_drained", 32'(bus_q.size()), 32'd0);
      check("rd_q_drained", 32'(rd_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
